nibrot_reg16: RTL
=================

# nibrot_reg16

Registered state stage for the 16-bit nibble-rotate datapath. It holds the word that the combinational next-state network computes from and feeds back into that network. It accepts clear, load, hold and multi-step rotate commands over a valid/ready handshake. It sequences rotates of 1–4 steps and signals completion with a one-cycle `done` pulse.

## Interface
Parameters:
- `NIB`, default 4: number of 4-bit nibbles. Data width is W = 4*NIB, so the default is 16 bits.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  stage can accept a command.
- `cmd_op`  in  2  operation code:
  - 00 hold
  - 01 clear
  - 10 load
  - 11 rotate
- `cmd_data`  in  W  load value; ignored unless op=10.
- `cmd_cnt`  in  2  rotate count; performs cnt+1 steps (1..4); ignored unless op=11.
- `q`  out  W  stored word.
- `busy`  out  1  rotate sequence in progress.
- `done`  out  1  one-cycle pulse: the command has fully completed.

## Operation
- Accept: a command is accepted on an edge where `cmd_valid & cmd_ready`.
- Ready: `cmd_ready = ~busy`.
- Rotate step: each nibble rotates right by one within itself. For each nibble k and bit i in 0..3, q[4k+i] <= q[4k+((i+1) mod 4)]. Nibbles never exchange bits.
- States: IDLE and ROT. The remaining-step counter `rem` is 2 bits.
- IDLE, command accepted:
  - hold: q unchanged.
  - clear: q <= 0.
  - load: q <= cmd_data.
  - rotate: one step applied at the accept edge. If cnt=0, stay IDLE. Otherwise go to ROT with rem <= cnt.
- ROT: one step per edge and rem decrements. On the edge where rem=1 the final step is applied and the state returns to IDLE.
- Commands never overlap. While in ROT, `cmd_ready=0` and `cmd_valid` is ignored.
- `done` is registered. It is high for exactly one cycle, the cycle after the edge that wrote the command's final q value. For hold, that is the accept edge.
- Handshake: the master must hold `cmd_valid`, `cmd_op`, `cmd_data` and `cmd_cnt` stable until accepted. Once accepted, the stage samples cnt and data only at the accept edge.

## Timing
- Reset values: q=0, busy=0, done=0, state IDLE, rem=0. With the macro enabled, parity=0.
- Reset has priority over everything. Reset during ROT aborts the rotate and no `done` is emitted. An accept that coincides with reset is dropped.
- Hold, clear and load: latency is 1 edge. `done` follows one cycle later. Back-to-back accepts every cycle are legal and give a `done` every cycle.
- Rotate with cnt=c:
  - Steps are applied at accept edge E and at E+1 .. E+c.
  - busy is high from after edge E through edge E+c, i.e. c cycles.
  - `done` is high in the cycle after edge E+c.
  - A new command may be accepted at edge E+c+1, in the same cycle `done` is high.
- cnt=3 (4 steps) leaves q equal to its pre-command value but still takes 4 edges.
- Width rule: rem never wraps. The counter does not decrement below 1 while in ROT.

## Configuration
- `NIBROT_PARITY_EN` defined: adds output `parity`, 1 bit, registered, equal to the XOR-reduction of q. It updates on the same edge as q and is reset to 0.
- Not defined: the `parity` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold rst for 2 cycles with `cmd_valid=1`, op=load, data=0xFFFF. Required: q=0x0000, busy=0, done=0 throughout. After release, ready=1.
- Load then single rotate: load 0x1234, then rotate cnt=0. Required: q=0x1234 with done the next cycle, then q=0x8192 with a single done. busy stays 0.
- Multi-step rotate: load 0x1234, then rotate cnt=1. Required: q=0x8192, then 0x48C1. busy=1 for 1 cycle, one done, and ready drops for exactly 1 cycle.
- Identity rotate with stall: load 0xA5C3, rotate cnt=3 while `cmd_valid` carries op=clear during busy. Required: 4 steps, then q=0xA5C3 and done. The pending clear is accepted only after busy falls, giving q=0x0000.
- Reset mid-rotate: load 0x0001, rotate cnt=3, assert rst at the second ROT edge. Required: q=0x0000, busy=0, no done pulse.
- Parity with `NIBROT_PARITY_EN` defined: load 0x0007. Required: parity=1. Then clear gives parity=0. Without the macro, the bench confirms the port is absent.

Source files
------------

// File: rtl/nibrot_reg16.sv
`default_nettype none
// ============================================================================
//  Module      : nibrot_reg16
//  Description : Registered state stage for the nibble-rotate datapath.
//                Accepts hold / clear / load / multi-step rotate commands
//                over a valid/ready handshake and pulses done on completion.
//                Optional macro NIBROT_PARITY_EN adds a registered parity
//                output (XOR-reduction of q).
//  Revision    : 1.0  initial release
// ============================================================================
module nibrot_reg16 #(
  parameter int NIB = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [4*NIB-1:0]   cmd_data,
  input  logic [1:0]         cmd_cnt,
  output logic [4*NIB-1:0]   q,
  output logic               busy,
  output logic               done
`ifdef NIBROT_PARITY_EN
  ,
  output logic               parity
`endif
);

  localparam int W = 4 * NIB;

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_ROT   = 2'b11;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ROT  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     rem_q,   rem_d;
  logic [W-1:0]   q_q,     q_d;
  logic           done_q,  done_d;
  logic [W-1:0]   rot_step;
  logic           accept;

  // One rotate step: each nibble rotates right by one bit, nibbles stay apart.
  for (genvar k = 0; k < NIB; k++) begin : g_nib
    assign rot_step[4*k+3 -: 4] = {q_q[4*k], q_q[4*k+3 -: 3]};
  end

  // Commands are only taken while idle; a rotate in flight blocks the port.
  assign accept = cmd_valid && (state_q == S_IDLE);

  // Next-state, next-data and completion pulse.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    q_d     = q_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_HOLD: begin
              done_d = 1'b1;
            end
            OP_CLEAR: begin
              q_d    = '0;
              done_d = 1'b1;
            end
            OP_LOAD: begin
              q_d    = cmd_data;
              done_d = 1'b1;
            end
            OP_ROT: begin
              // First step happens on the accept edge itself.
              q_d = rot_step;
              if (cmd_cnt == 2'd0) begin
                done_d = 1'b1;
              end else begin
                state_d = S_ROT;
                rem_d   = cmd_cnt;
              end
            end
            default: begin
              done_d = 1'b0;
            end
          endcase
        end
      end
      S_ROT: begin
        q_d = rot_step;
        // rem==1 is the final step; the counter never goes below 1 here.
        if (rem_q <= 2'd1) begin
          state_d = S_IDLE;
          rem_d   = 2'd0;
          done_d  = 1'b1;
        end else begin
          rem_d = rem_q - 2'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        rem_d   = 2'd0;
      end
    endcase
  end

  // State registers; reset wins over any command on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= 2'd0;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

`ifdef NIBROT_PARITY_EN
  logic parity_q, parity_d;

  // Parity tracks the word being written, so it updates with q.
  always_comb begin
    parity_d = ^q_d;
  end

  // Parity register.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity = parity_q;
`endif

  assign q         = q_q;
  assign busy      = (state_q == S_ROT);
  assign cmd_ready = (state_q != S_ROT);
  assign done      = done_q;

endmodule
`default_nettype wire
